branch_predictor: RTL
=====================

# branch_predictor

Dynamic branch predictor and redirect controller for the pipelined core. Gives fetch a next-PC prediction from a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. It checks execute-stage resolution (the `pc_sel` outcome from the branch unit) against the prediction carried down the pipe, and raises a flush with the corrected PC on mismatch. It trains the table and keeps branch and mispredict statistics.

## Interface
- `DATA_WIDTH`, 32: PC and target width.
- `INDEX_BITS`, 4: log2 of BTB entries (16 entries); index = `pc[INDEX_BITS+1:2]`, tag = `pc[DATA_WIDTH-1:INDEX_BITS+2]`.

Ports:
- `clk` input 1: the single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `fetch_pc` input DATA_WIDTH: PC being fetched this cycle.
- `pred_taken` output 1: fetch-side prediction, taken.
- `pred_next_pc` output DATA_WIDTH: predicted next PC; fetch carries it down the pipe with the instruction.
- `ex_valid` input 1: a valid instruction is in execute this cycle.
- `ex_pc` input DATA_WIDTH: its PC.
- `ex_is_branch` input 1: conditional branch (beq/bne/blt/bge/bltu/bgeu).
- `ex_is_jump` input 1: jal/jalr.
- `ex_pc_sel` input 1: branch unit outcome.
- `ex_target` input DATA_WIDTH: computed branch/jump target.
- `ex_pred_next_pc` input DATA_WIDTH: `pred_next_pc` carried from fetch.
- `mispredict` output 1: flush request; squash younger stages.
- `redirect_pc` output DATA_WIDTH: corrected PC, meaningful when `mispredict`=1.
- `branch_count` output 32: count of resolved control-flow instructions.
- `mispredict_count` output 32: count of mispredicts.

## Operation
- Entry fields: `valid`, `tag`, `target`, `ctr[1:0]`, `jump`.
- Lookup (combinational):
  - hit = `valid` && tag match on `fetch_pc`.
  - `pred_taken` = hit && (`jump` || `ctr[1]`).
  - `pred_next_pc` = `pred_taken` ? `target` : `fetch_pc`+4.
- Resolution (combinational):
  - cf = `ex_is_branch` | `ex_is_jump`.
  - taken = `ex_is_jump` | (`ex_is_branch` & `ex_pc_sel`).
  - actual = taken ? `ex_target` : `ex_pc`+4.
  - `mispredict` = `ex_valid` && (`ex_pred_next_pc` != actual). This covers both wrong direction and wrong target (jalr).
  - `redirect_pc` = actual whenever `ex_valid`, else `ex_pc`+4.
- Training (clock edge, `ex_valid` && cf):
  - Hit at `ex_pc`: `ctr` increments if taken, decrements if not, saturating at 11 and 00. `jump` <= `ex_is_jump`. If taken, `target` <= `ex_target`.
  - Miss, taken: allocate, replacing any occupant. Set `valid`=1, tag, `target`=`ex_target`, `ctr`=10, `jump`=`ex_is_jump`.
  - Miss, not taken: no allocation.
- Stale entry: `ex_valid` && !cf && hit at `ex_pc` clears that entry's `valid`.
- Statistics:
  - `branch_count` increments on `ex_valid` && cf.
  - `mispredict_count` increments on `mispredict`.
  - Both saturate at 0xFFFFFFFF.
- Arithmetic: all +4 additions are mod 2^DATA_WIDTH, so 0xFFFFFFFC+4 = 0.

## Timing
- Lookup and resolution have zero latency, combinational from inputs in the same cycle.
- A table update becomes visible to lookup in the following cycle.
- If fetch and execute touch the same index in the same cycle, fetch sees the pre-update contents.
- `mispredict` is a level asserted only in cycles where the condition holds. The pipeline's flush removes the wrong-path instruction, so a mispredict is never asserted twice for the same instruction.
- Reset, in the cycle `rst`=1:
  - all `valid`=0, all `ctr`=01, `jump`=0, `target`=0;
  - counters return to 0;
  - table and counter updates in that cycle are suppressed.
- During reset, outputs are combinational from inputs: `pred_taken`=0, `pred_next_pc`=`fetch_pc`+4, and `mispredict`/`redirect_pc` follow the resolution equations.
- A reset during training discards that cycle's update.

## Test plan
- Reset, then `fetch_pc`=0x100: `pred_taken`=0, `pred_next_pc`=0x104, both counters 0.
- Resolve taken beq at 0x100, target 0x40, `ex_pred_next_pc`=0x104: `mispredict`=1, `redirect_pc`=0x40. Next cycle, fetch 0x100 gives `pred_taken`=1, `pred_next_pc`=0x40; `branch_count`=1, `mispredict_count`=1.
- Same branch resolved not-taken twice, with correct predictions supplied: ctr goes 10→01→00. Fetch 0x100 then predicts 0x104. A third not-taken keeps ctr=00 (saturation).
- Train jalr at 0x200 to 0x80, then resolve it with target 0x90 while carrying 0x80: `mispredict`=1, `redirect_pc`=0x90. Next lookup gives 0x90.
- Alias: train 0x100 taken to 0x40, then fetch 0x140 (same index, different tag): `pred_taken`=0. Train 0x140 taken to 0x60: fetch 0x100 now misses.
- Same-cycle conflict: fetch 0x100 while ex allocates 0x100, giving old (miss) prediction that cycle and a hit the next. Assert `rst` mid-sequence: the table clears and counters return to 0 on the next cycle.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit direction counters, execute-stage
// mispredict detection with redirect PC, table training and saturating statistics.
//
// Qualifier semantics: ex_valid alone qualifies every ex_* input in the cycle it is
// high; there is no ready/backpressure, so resolution and training always complete
// in that same cycle. Fetch lookup is unqualified and evaluated every cycle.
module branch_predictor #(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fetch_pc,
    output logic                  pred_taken,
    output logic [DATA_WIDTH-1:0] pred_next_pc,
    input  logic                  ex_valid,
    input  logic [DATA_WIDTH-1:0] ex_pc,
    input  logic                  ex_is_branch,
    input  logic                  ex_is_jump,
    input  logic                  ex_pc_sel,
    input  logic [DATA_WIDTH-1:0] ex_target,
    input  logic [DATA_WIDTH-1:0] ex_pred_next_pc,
    output logic                  mispredict,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = DATA_WIDTH - INDEX_BITS - 2;
    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    // BTB storage, one field per array
    logic                  btb_valid  [ENTRIES];
    logic [TAG_BITS-1:0]   btb_tag    [ENTRIES];
    logic [DATA_WIDTH-1:0] btb_target [ENTRIES];
    logic [1:0]            btb_ctr    [ENTRIES];
    logic                  btb_jump   [ENTRIES];

    logic [INDEX_BITS-1:0] fetch_idx;
    logic [TAG_BITS-1:0]   fetch_tag;
    logic                  fetch_hit;
    logic [DATA_WIDTH-1:0] fetch_seq;

    logic [INDEX_BITS-1:0] ex_idx;
    logic [TAG_BITS-1:0]   ex_tag;
    logic                  ex_hit;
    logic                  ex_cf;
    logic                  ex_taken;
    logic [DATA_WIDTH-1:0] ex_seq;
    logic [DATA_WIDTH-1:0] ex_actual;
    logic [1:0]            ctr_next;

    assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
    assign fetch_tag = fetch_pc[DATA_WIDTH-1:INDEX_BITS+2];
    assign ex_idx    = ex_pc[INDEX_BITS+1:2];
    assign ex_tag    = ex_pc[DATA_WIDTH-1:INDEX_BITS+2];

    // Fetch-side lookup; reset forces a not-taken prediction regardless of table contents
    always_comb begin
        fetch_seq    = fetch_pc + PC_STEP;
        fetch_hit    = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
        pred_taken   = !rst && fetch_hit && (btb_jump[fetch_idx] || btb_ctr[fetch_idx][1]);
        pred_next_pc = pred_taken ? btb_target[fetch_idx] : fetch_seq;
    end

    // Execute-side resolution: compare the carried prediction with the real next PC
    always_comb begin
        ex_seq      = ex_pc + PC_STEP;
        ex_cf       = ex_is_branch | ex_is_jump;
        ex_taken    = ex_is_jump | (ex_is_branch & ex_pc_sel);
        ex_actual   = ex_taken ? ex_target : ex_seq;
        ex_hit      = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
        mispredict  = ex_valid && (ex_pred_next_pc != ex_actual);
        redirect_pc = ex_valid ? ex_actual : ex_seq;
    end

    // Saturating direction counter step for the entry being trained
    always_comb begin
        ctr_next = btb_ctr[ex_idx];
        if (ex_taken) begin
            if (btb_ctr[ex_idx] != 2'b11) ctr_next = btb_ctr[ex_idx] + 2'd1;
        end else begin
            if (btb_ctr[ex_idx] != 2'b00) ctr_next = btb_ctr[ex_idx] - 2'd1;
        end
    end

    // Table training and stale-entry invalidation; reset wipes the table and drops the update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= 2'b01;
                btb_jump[i]   <= 1'b0;
            end
        end else if (ex_valid && ex_cf) begin
            if (ex_hit) begin
                btb_ctr[ex_idx]  <= ctr_next;
                btb_jump[ex_idx] <= ex_is_jump;
                if (ex_taken) btb_target[ex_idx] <= ex_target;
            end else if (ex_taken) begin
                // Miss on a taken transfer: evict whatever lives at this index
                btb_valid[ex_idx]  <= 1'b1;
                btb_tag[ex_idx]    <= ex_tag;
                btb_target[ex_idx] <= ex_target;
                btb_ctr[ex_idx]    <= 2'b10;
                btb_jump[ex_idx]   <= ex_is_jump;
            end
        end else if (ex_valid && ex_hit) begin
            // A non-control-flow instruction sits at this PC now: the entry is stale
            btb_valid[ex_idx] <= 1'b0;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (ex_valid && ex_cf && (branch_count != 32'hFFFF_FFFF))
                branch_count <= branch_count + 32'd1;
            if (mispredict && (mispredict_count != 32'hFFFF_FFFF))
                mispredict_count <= mispredict_count + 32'd1;
        end
    end

endmodule
